// File: rtl/numerical_integral_pkg.sv
// numerical_integral_pkg
// Shared constants for the running-sum integrator.
//   INTEG_W   : default data/accumulator width in bits
//   INTEG_RST : reset value of the accumulator and the previous-sample register
package numerical_integral_pkg;

  localparam int                 INTEG_W   = 64;
  localparam logic [INTEG_W-1:0] INTEG_RST = '0;

endpackage

// File: rtl/numerical_integral_if.sv
// numerical_integral_if
// Bundles the sample/enable/result signals of one integrator instance.
//   signal_input      : unsigned sample (caller-owned fixed-point scale)
//   start_integration : level enable, integrate while high
//   integral_result   : registered accumulator value
// Modports:
//   master : the side feeding samples and reading the total
//   slave  : the integrator side
// Handshake: none. The enable is a plain level sampled on every rising
// edge together with the data; there is no valid/ready pair and no
// backpressure, one sample is consumed per enabled clock.
interface numerical_integral_if #(
  parameter int N = numerical_integral_pkg::INTEG_W
);

  logic [N-1:0] signal_input;
  logic         start_integration;
  logic [N-1:0] integral_result;

  modport master (
    output signal_input,
    output start_integration,
    input  integral_result
  );

  modport slave (
    input  signal_input,
    input  start_integration,
    output integral_result
  );

endinterface

// File: rtl/integral_step_area.sv
// integral_step_area
// Combinational step-area rule of the integrator.
//   signal_input : current sample
//   x_prev       : sample accepted on the previous enabled edge
//   prev_valid   : x_prev belongs to an uninterrupted run of enabled edges
//   area         : amount to add to the accumulator this edge
// Build option NUMERICAL_INTEGRAL_TRAPEZOID_EN:
//   defined   -> trapezoidal rule, (x + x_prev) >> 1, or x when prev_valid=0
//   undefined -> rectangular rule, area = x
module integral_step_area
  import numerical_integral_pkg::*;
#(
  parameter int N = INTEG_W
) (
  input  logic [N-1:0] signal_input,
  input  logic [N-1:0] x_prev,
  input  logic         prev_valid,
  output logic [N-1:0] area
);

`ifdef NUMERICAL_INTEGRAL_TRAPEZOID_EN
  // Sum kept at N+1 bits so the average of two full-scale samples is exact.
  logic [N:0] sum;

  always_comb begin
    sum  = {1'b0, signal_input} + {1'b0, x_prev};
    area = prev_valid ? sum[N:1] : signal_input;
  end
`else
  // Rectangular rule ignores history; keep the inputs referenced.
  logic unused_hist;
  assign unused_hist = ^{x_prev, prev_valid};
  assign area        = signal_input;
`endif

endmodule

// File: rtl/numerical_integral.sv
// numerical_integral
// Running-sum integrator: on every rising edge with start_integration=1 the
// step area of signal_input is added (mod 2^N) to the accumulator. With the
// enable low the total is frozen. Only reset clears it.
// Ports:
//   clk               : rising-edge clock
//   resetb            : asynchronous active-low reset
//   signal_input      : unsigned sample, N bits
//   start_integration : level enable
//   integral_result   : accumulator, driven straight from the register
// Build option NUMERICAL_INTEGRAL_TRAPEZOID_EN selects the trapezoidal rule
// (see integral_step_area); default is the rectangular rule.
module numerical_integral
  import numerical_integral_pkg::*;
#(
  parameter int N = INTEG_W
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic [N-1:0] signal_input,
  input  logic         start_integration,
  output logic [N-1:0] integral_result
);

  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] x_prev_q, x_prev_d;
  logic         prev_valid_q, prev_valid_d;
  logic [N-1:0] area;

  integral_step_area #(.N(N)) u_step_area (
    .signal_input (signal_input),
    .x_prev       (x_prev_q),
    .prev_valid   (prev_valid_q),
    .area         (area)
  );

  // Disabled edges hold acc and x_prev, so an unknown sample while the
  // enable is low never reaches state. prev_valid drops so the first sample
  // after a gap is integrated in full.
  always_comb begin
    acc_d        = acc_q;
    x_prev_d     = x_prev_q;
    prev_valid_d = 1'b0;
    if (start_integration) begin
      acc_d        = acc_q + area;
      x_prev_d     = signal_input;
      prev_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      acc_q        <= N'(INTEG_RST);
      x_prev_q     <= N'(INTEG_RST);
      prev_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      x_prev_q     <= x_prev_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  assign integral_result = acc_q;

endmodule

// File: tb/tb_numerical_integral.sv
// tb_numerical_integral
// Directed table of {reset, enable, sample, expected result} records applied
// one per clock. Expected totals are hand-computed for both the rectangular
// and trapezoidal builds; the build in use picks the column.
module tb_numerical_integral;

  localparam int W = 64;
  localparam logic [W-1:0] MAX = {W{1'b1}};

  typedef struct {
    logic         rst;
    logic         en;
    logic [W-1:0] x;
    logic [W-1:0] exp_rect;
    logic [W-1:0] exp_trap;
  } vec_t;

  logic clk;
  logic resetb;

  numerical_integral_if #(.N(W)) bus ();

  numerical_integral #(.N(W)) dut (
    .clk               (clk),
    .resetb            (resetb),
    .signal_input      (bus.signal_input),
    .start_integration (bus.start_integration),
    .integral_result   (bus.integral_result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  vec_t         vec_q[$];
  logic [W-1:0] exp_q[$];
  int           checks   = 0;
  int           failures = 0;

  task automatic check(input string name, input logic [W-1:0] act);
    logic [W-1:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic rst, input logic en, input logic [W-1:0] x,
                         input logic [W-1:0] er, input logic [W-1:0] et);
    vec_t v;
    v.rst = rst; v.en = en; v.x = x; v.exp_rect = er; v.exp_trap = et;
    vec_q.push_back(v);
  endtask

  function automatic logic [W-1:0] pick(input vec_t v);
`ifdef NUMERICAL_INTEGRAL_TRAPEZOID_EN
    return v.exp_trap;
`else
    return v.exp_rect;
`endif
  endfunction

  // ---------------- driver ----------------
  // Inputs change on the falling edge; the result is sampled 1 time unit
  // after the rising edge. A reset record also checks the output before the
  // next rising edge to prove the clear is asynchronous.
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    bus.signal_input      = v.x;
    bus.start_integration = v.en;
    if (v.rst) begin
      resetb = 1'b0;
      #2;
      exp_q.push_back('0);
      check($sformatf("async_reset[%0d]", idx), bus.integral_result);
    end else begin
      resetb = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(pick(v));
    check($sformatf("vec[%0d]", idx), bus.integral_result);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetb                = 1'b0;
    bus.signal_input      = '0;
    bus.start_integration = 1'b0;
    #1;
    exp_q.push_back('0);
    check("power_on_reset", bus.integral_result);

    // reset, constant 10 for five cycles
    add_vec(1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) add_vec(0, 1, 10, 64'(10*i), 64'(10*i));
    add_vec(0, 0, 0, 50, 50);
    // 100 after a gap: full sample first, then averages of equal samples
    for (int i = 1; i <= 5; i++) add_vec(0, 1, 100, 64'(50+100*i), 64'(50+100*i));
    // mid-run reset with acc=550, stays 0 while disabled
    add_vec(1, 0, 0, 0, 0);
    add_vec(0, 0, 77, 0, 0);
    // ramp 0,2,4,6
    add_vec(0, 1, 0, 0, 0);
    add_vec(0, 1, 2, 2, 1);
    add_vec(0, 1, 4, 6, 4);
    add_vec(0, 1, 6, 12, 9);
    // hold/resume
    add_vec(1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) add_vec(0, 1, 7, 64'(7*i), 64'(7*i));
    add_vec(0, 0, 99, 21, 21);
    add_vec(0, 0, 'x, 21, 21);
    add_vec(0, 0, 99, 21, 21);
    add_vec(0, 0, 0, 21, 21);
    add_vec(0, 1, 7, 28, 28);
    add_vec(0, 1, 5, 33, 34);
    // enable edge alignment: dropping edge ignores 5, rising edge takes 5
    add_vec(0, 0, 5, 33, 34);
    add_vec(0, 1, 5, 38, 39);
    // wrap-around
    add_vec(1, 0, 0, 0, 0);
    add_vec(0, 1, MAX, MAX, MAX);
    add_vec(0, 0, 0, MAX, MAX);
    add_vec(0, 1, 2, 1, 1);
    add_vec(0, 1, MAX, 0, 64'h8000_0000_0000_0001);
    add_vec(0, 1, MAX, MAX, 64'h8000_0000_0000_0000);

    for (int i = 0; i < vec_q.size(); i++) apply(i, vec_q[i]);

    // hand sequence: reset held across several enabled edges keeps output 0
    @(negedge clk);
    resetb                = 1'b0;
    bus.start_integration = 1'b1;
    bus.signal_input      = 64'd123;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back('0);
      check($sformatf("reset_held[%0d]", i), bus.integral_result);
    end
    // release: first enabled edge performs the first accumulation
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(64'd123);
    check("first_after_release", bus.integral_result);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
